// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator side of the data-memory interface.
// Takes one load/store at a time from the datapath, drives the memory strobes,
// waits out the fixed read latency, and returns a one-cycle response pulse.
//
// Handshake: a request is accepted on the rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE, so a request
// presented in any other state is ignored, not queued. The response is a
// single-cycle rsp_valid pulse with no back-pressure. rsp_err qualifies
// that pulse.
//
// The read latency LAT (legal 1..15) counts from the edge that samples a read
// strobe to the edge that captures mem_rdata.
module mem_access_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 65536,
  parameter int LAT       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [7:0]        err_cnt,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // The range limit is one bit wider than the address. A MEM_WORDS equal to
  // 2**ADDR_W therefore still compares correctly, and no address bit is dropped.
  localparam logic [ADDR_W:0] LP_LIMIT    = (ADDR_W + 1)'(MEM_WORDS);
  localparam logic [3:0]      LP_CNT_INIT = 4'(LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_we;
  logic              r_err;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [7:0]        r_err_cnt;

  logic              w_accept;
  logic              w_in_range;
  logic              w_wait_done;

  assign w_accept    = (r_state == S_IDLE) && req_valid;
  assign w_in_range  = ({1'b0, req_addr} < LP_LIMIT);
  assign w_wait_done = (r_state == S_WAIT) && (r_cnt == 4'd0);

  // State register; an asynchronous reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_next = w_in_range ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE: begin
        w_next = r_we ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Latch the request on acceptance. Out-of-range requests keep the previous
  // memory address and data, so their store data is dropped. They only set the
  // error flag and bump the saturating error count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_err_cnt <= 8'd0;
    end else if (w_accept) begin
      r_we  <= req_we;
      r_err <= !w_in_range;
      if (w_in_range) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end else if (r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  // Read-latency countdown. It is loaded while the read strobe is out and
  // counts down in WAIT, which therefore lasts exactly LAT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= LP_CNT_INIT;
    end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Load data capture. The value is held until the next successful load, so
  // stores and out-of-range accesses leave it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_wait_done) begin
      r_rdata <= mem_rdata;
    end
  end

  // Outputs decoded from state. mem_en therefore falls as soon as rst rises.
  assign req_ready = (r_state == S_IDLE);
  assign stall     = ((r_state == S_IDLE) && req_valid) ||
                     (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_err   = (r_state == S_RESP) && r_err;
  assign rsp_rdata = r_rdata;
  assign err_cnt   = r_err_cnt;
  assign mem_en    = (r_state == S_ISSUE);
  assign mem_rw    = (r_state == S_ISSUE) && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl. It builds three instances with read latencies
// 1, 3 and 4. Each instance has its own memory model: a write array plus a
// read pipeline that shows random noise outside the exact capture cycle.
// Expected responses come from a transaction-level model. That model gives the
// latency as a number of cycles, keeps a shadow memory, holds the last load
// value, and keeps a saturating error count.
module tb_mem_access_ctrl;

  localparam int MEMW = 65536;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        rst_v;
  logic [2:0]        req_valid_v;
  logic [2:0]        req_we_v;
  logic [2:0][31:0]  req_addr_v;
  logic [2:0][31:0]  req_wdata_v;
  logic [2:0]        req_ready_v;
  logic [2:0]        stall_v;
  logic [2:0]        rsp_valid_v;
  logic [2:0]        rsp_err_v;
  logic [2:0][31:0]  rsp_rdata_v;
  logic [2:0][7:0]   err_cnt_v;
  logic [2:0]        mem_en_v;
  logic [2:0]        mem_rw_v;
  logic [2:0][31:0]  mem_addr_v;
  logic [2:0][31:0]  mem_wdata_v;
  logic [2:0][31:0]  mem_rdata_v;
  logic [2:0][1:0]   dbg_state_v;

  logic [31:0] mem_m  [3][MEMW];
  logic [31:0] shadow [3][MEMW];
  logic [31:0] pipe   [3][16];

  logic [31:0] m_rdata [3];
  int          m_errcnt [3];

  int n_total = 0;
  int n_bad   = 0;

  function automatic int lat_of(input int g);
    case (g)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .MEM_WORDS(MEMW), .LAT(L)) u_dut (
      .clk       (clk),
      .rst       (rst_v[g]),
      .req_valid (req_valid_v[g]),
      .req_we    (req_we_v[g]),
      .req_addr  (req_addr_v[g]),
      .req_wdata (req_wdata_v[g]),
      .req_ready (req_ready_v[g]),
      .stall     (stall_v[g]),
      .rsp_valid (rsp_valid_v[g]),
      .rsp_err   (rsp_err_v[g]),
      .rsp_rdata (rsp_rdata_v[g]),
      .err_cnt   (err_cnt_v[g]),
      .mem_en    (mem_en_v[g]),
      .mem_rw    (mem_rw_v[g]),
      .mem_addr  (mem_addr_v[g]),
      .mem_wdata (mem_wdata_v[g]),
      .mem_rdata (mem_rdata_v[g]),
      .dbg_state (dbg_state_v[g])
    );
    assign mem_rdata_v[g] = pipe[g][L-1];
  end

  // Memory models: a write on a sampled write strobe, and read data that sits
  // on mem_rdata exactly LAT edges after the sampled read strobe.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      pipe[g][0] <= (mem_en_v[g] && !mem_rw_v[g]) ? mem_m[g][mem_addr_v[g][15:0]] : $urandom;
      for (int k = 1; k < 16; k++) pipe[g][k] <= pipe[g][k-1];
      if (mem_en_v[g] && mem_rw_v[g]) mem_m[g][mem_addr_v[g][15:0]] = mem_wdata_v[g];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int g);
    m_rdata[g]  = 32'd0;
    m_errcnt[g] = 0;
  endtask

  // Runs one access. It starts in the cycle after a rising edge, while the
  // instance is idle. With noise set, req_valid stays high with junk requests
  // until the response cycle; these junk requests must be ignored.
  task automatic access(input int g, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit noise);
    logic [31:0] exp_q[$];
    int  exp_lat, cyc, n_en, n_stall;
    bit  oor, got_rsp;
    oor     = (addr >= MEMW);
    exp_lat = oor ? 1 : (we ? 2 : 2 + lat_of(g));
    if (oor) begin
      if (m_errcnt[g] < 255) m_errcnt[g]++;
      exp_q.push_back(m_rdata[g]);
    end else if (we) begin
      exp_q.push_back(m_rdata[g]);
    end else begin
      exp_q.push_back(shadow[g][addr[15:0]]);
    end
    req_valid_v[g] = 1'b1; req_we_v[g] = we; req_addr_v[g] = addr; req_wdata_v[g] = wdata;
    cyc = 0; n_en = 0; n_stall = 0; got_rsp = 0;
    while (!got_rsp && cyc < 40) begin
      @(negedge clk);
      if (cyc == 0) chk("ready_idle", 32'(req_ready_v[g]), 32'd1);
      if (stall_v[g]) n_stall++;
      if (mem_en_v[g]) begin
        n_en++;
        chk("mem_rw", 32'(mem_rw_v[g]), 32'(we));
        chk("mem_addr", mem_addr_v[g], addr);
        if (we) chk("mem_wdata", mem_wdata_v[g], wdata);
      end
      if (rsp_valid_v[g]) begin
        got_rsp = 1;
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("rsp_err", 32'(rsp_err_v[g]), 32'(oor));
        chk("rsp_rdata", rsp_rdata_v[g], exp_q.pop_front());
        chk("err_cnt", 32'(err_cnt_v[g]), 32'(m_errcnt[g]));
      end
      @(posedge clk); #1;
      if (!noise || got_rsp) begin
        req_valid_v[g] = 1'b0;
      end else begin
        req_we_v[g] = 1'($urandom); req_addr_v[g] = $urandom_range(0, 70000); req_wdata_v[g] = $urandom;
      end
      cyc++;
    end
    if (!got_rsp) chk("rsp_timeout", 32'd0, 32'd1);
    chk("mem_en_pulses", 32'(n_en), oor ? 32'd0 : 32'd1);
    chk("stall_cycles", 32'(n_stall), 32'(exp_lat));
    if (!oor && we) shadow[g][addr[15:0]] = wdata;
    if (!oor && !we) m_rdata[g] = shadow[g][addr[15:0]];
  endtask

  // Four stores with req_valid held high throughout. Each store occupies ISSUE
  // and RESP, then the next one is accepted at the end of the following IDLE
  // cycle, so the write strobes are 3 cycles apart.
  task automatic stream_stores();
    int en_cyc[$];
    int n_acc, n_rsp, k;
    bit acc;
    logic [31:0] a [4];
    logic [31:0] d [4];
    for (int i = 0; i < 4; i++) begin a[i] = 32'(100 + i); d[i] = $urandom; end
    n_acc = 0; n_rsp = 0;
    req_valid_v[0] = 1'b1; req_we_v[0] = 1'b1; req_addr_v[0] = a[0]; req_wdata_v[0] = d[0];
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      acc = req_ready_v[0] && req_valid_v[0];
      if (mem_en_v[0]) begin
        k = en_cyc.size();
        if (k < 4) begin
          chk("stream_addr", mem_addr_v[0], a[k]);
          chk("stream_wdata", mem_wdata_v[0], d[k]);
        end
        en_cyc.push_back(c);
      end
      if (rsp_valid_v[0]) n_rsp++;
      @(posedge clk); #1;
      if (acc) begin
        n_acc++;
        if (n_acc == 4) req_valid_v[0] = 1'b0;
        else begin req_addr_v[0] = a[n_acc]; req_wdata_v[0] = d[n_acc]; end
      end
    end
    chk("stream_en_count", 32'(en_cyc.size()), 32'd4);
    chk("stream_rsp_count", 32'(n_rsp), 32'd4);
    for (int i = 1; i < en_cyc.size(); i++)
      chk("stream_spacing", 32'(en_cyc[i] - en_cyc[i-1]), 32'd3);
    for (int i = 0; i < 4; i++) shadow[0][a[i][15:0]] = d[i];
    for (int i = 0; i < 4; i++) access(0, 1'b0, a[i], 32'd0, 1'b0);
  endtask

  task automatic check_reset_outputs(input int g, input string tag);
    chk({tag, "_ready"}, 32'(req_ready_v[g]), 32'd1);
    chk({tag, "_stall"}, 32'(stall_v[g]), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid_v[g]), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err_v[g]), 32'd0);
    chk({tag, "_mem_en"}, 32'(mem_en_v[g]), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata_v[g], 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt_v[g]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int kind;
    logic [31:0] addr;
    rst_v = 3'b111; req_valid_v = '0; req_we_v = '0; req_addr_v = '0; req_wdata_v = '0;
    for (int g = 0; g < 3; g++) begin
      model_reset(g);
      for (int a = 0; a < 256; a++) begin v = $urandom; mem_m[g][a] = v; shadow[g][a] = v; end
      v = $urandom; mem_m[g][MEMW-1] = v; shadow[g][MEMW-1] = v;
    end
    mem_m[2][0] = 32'h0000_0011; shadow[2][0] = 32'h0000_0011;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check_reset_outputs(g, "rst");
      chk("rst_mem_rw", 32'(mem_rw_v[g]), 32'd0);
      chk("rst_mem_addr", mem_addr_v[g], 32'd0);
      chk("rst_mem_wdata", mem_wdata_v[g], 32'd0);
    end
    @(posedge clk); #1;
    rst_v = 3'b000;

    // Store then load at LAT=1.
    access(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0);
    access(0, 1'b0, 32'd5, 32'd0, 1'b0);
    // Load at LAT=4 from word 0, which holds 0x11.
    access(2, 1'b0, 32'd0, 32'd0, 1'b0);
    // Out-of-range load: no strobe, error response, rdata unchanged.
    access(0, 1'b0, 32'd65536, 32'd0, 1'b0);
    access(0, 1'b1, 32'd65535, 32'h1234_5678, 1'b0);
    access(0, 1'b0, 32'd65535, 32'd0, 1'b0);
    access(0, 1'b1, 32'hFFFF_FFFF, 32'hAAAA_5555, 1'b0);
    // Error counter saturation.
    for (int i = 0; i < 300; i++) access(0, 1'($urandom), 32'(MEMW + $urandom_range(0, 1000)), $urandom, 1'b0);
    chk("err_cnt_sat", 32'(err_cnt_v[0]), 32'd255);

    stream_stores();

    // Randomized traffic on every instance.
    for (int n = 0; n < 40; n++) begin
      for (int g = 0; g < 3; g++) begin
        kind = $urandom_range(0, 9);
        if (kind < 7)       addr = $urandom_range(0, 63);
        else if (kind == 7) addr = 32'(MEMW - 1);
        else if (kind == 8) addr = 32'(MEMW);
        else                addr = $urandom;
        access(g, 1'($urandom), addr, $urandom, 1'($urandom));
      end
    end

    // Reset during WAIT of a LAT=3 load.
    access(1, 1'b0, 32'd70000, 32'd0, 1'b0);
    req_valid_v[1] = 1'b1; req_we_v[1] = 1'b0; req_addr_v[1] = 32'd7;
    @(posedge clk); #1; req_valid_v[1] = 1'b0;
    @(posedge clk); #1;
    #2 rst_v[1] = 1'b1;
    #1 check_reset_outputs(1, "rst_wait");
    model_reset(1);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_rsp_valid", 32'(rsp_valid_v[1]), 32'd0);
      chk("rst_hold_mem_en", 32'(mem_en_v[1]), 32'd0);
    end
    @(posedge clk); #1; rst_v[1] = 1'b0;
    access(1, 1'b0, 32'd7, 32'd0, 1'b0);

    // Reset while the read strobe is out: it must fall without a clock edge.
    req_valid_v[2] = 1'b1; req_we_v[2] = 1'b0; req_addr_v[2] = 32'd3;
    @(posedge clk); #1; req_valid_v[2] = 1'b0;
    #2 chk("issue_mem_en", 32'(mem_en_v[2]), 32'd1);
    rst_v[2] = 1'b1;
    #1 check_reset_outputs(2, "rst_issue");
    model_reset(2);
    @(posedge clk); #1; rst_v[2] = 1'b0;
    access(2, 1'b0, 32'd3, 32'd0, 1'b0);
    access(2, 1'b0, 32'd0, 32'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
